fft_peak_finder: RTL
====================

# fft_peak_finder

Downstream consumer of the FFT sample memory. Once the spectrum is in memory, it scans the magnitude bins through the memory's read port and reports the bin index and magnitude of the strongest component. The tuner's note/pitch logic uses these results. It replaces the free-running read sequencer used during bring-up and adds a start/busy/done handshake.

## Interface
Parameters:
- ADDR_W, 11, memory address width
- DATA_W, 10, magnitude word width (unsigned)
- N_BINS, 1024, one past the last bin scanned (bins MIN_BIN..N_BINS-1)
- MIN_BIN, 1, first bin scanned; excludes DC

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a scan
- thresh  in  DATA_W  minimum magnitude for a valid peak; sampled on accepted start
- rd_en  out  1  memory read enable, high while addresses are issued
- addr  out  ADDR_W  memory read address
- data_in  in  DATA_W  memory read data, valid one cycle after addr/rd_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results are updated
- peak_bin  out  ADDR_W  index of the maximum bin
- peak_mag  out  DATA_W  magnitude at peak_bin
- peak_valid  out  1  peak_mag >= latched thresh
- nb_left, nb_right  out  DATA_W  magnitudes of bins peak_bin-1 / peak_bin+1 (only with PEAK_NEIGHBORS_EN)

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 latches thresh, clears the running max (max_mag=0, max_bin=MIN_BIN) and moves to SCAN with addr=MIN_BIN.
- SCAN: rd_en=1; addr increments by 1 each cycle. After addr=N_BINS-1 is issued, the block goes to DRAIN.
- Compare stage: a delayed copy of rd_en/addr tags each data_in. When data_in > max_mag (strict), the running max updates to (addr_d, data_in). Ties keep the lowest bin.
- DRAIN: rd_en=0; the last returned sample is compared.
- DONE: peak_bin, peak_mag, peak_valid and the neighbours load from the running registers. done=1 for this cycle only, then the block returns to IDLE.
- If every bin is 0, the result is peak_bin=MIN_BIN, peak_mag=0, and peak_valid=(thresh==0).
- start is ignored in SCAN, DRAIN and DONE; it is neither queued nor counted.
- Result outputs hold their values between done pulses and stay stable during a new scan.

## Timing
- Reset values: rd_en=0, addr=0, busy=0, done=0, peak_bin=0, peak_mag=0, peak_valid=0, nb_left=0, nb_right=0. State is IDLE.
- Asserting rst mid-scan aborts immediately. No done is produced, and results return to their reset values.
- Counting start as cycle 0:
  - SCAN occupies cycles 1..N_BINS-MIN_BIN.
  - DRAIN occupies cycle N_BINS-MIN_BIN+1.
  - DONE (done=1) occupies cycle N_BINS-MIN_BIN+2. With defaults this is cycle 1025.
- busy is high over cycles 1..N_BINS-MIN_BIN+2 inclusive.
- The earliest accepted restart is the cycle after done (IDLE).
- No wrap-around: addr never exceeds N_BINS-1. After DRAIN, addr holds its last value until the next start.

## Configuration
- PEAK_NEIGHBORS_EN defined:
  - The block keeps the previous sample. When the max updates, it captures nb_left as the previous sample and arms a capture of nb_right from the next sample.
  - nb_left=0 when the peak is MIN_BIN. nb_right=0 when the peak is N_BINS-1.
  - An armed right capture is overwritten if a new max occurs on that next sample.
- PEAK_NEIGHBORS_EN undefined: the nb_left and nb_right ports and their logic are absent.

## Test plan
- Single tone: mem[200]=700, all other bins 10, thresh=100, start pulse. Expect done at cycle 1025, peak_bin=200, peak_mag=700, peak_valid=1, and (with the macro) nb_left=10, nb_right=10.
- Tie and DC: mem[0]=1023, mem[50]=mem[300]=500, all others 0. Expect peak_bin=50 and peak_mag=500 (DC excluded, lowest tie wins).
- Threshold and all-zero: all bins 0 with thresh=0 gives peak_bin=1, peak_valid=1. All bins 0 with thresh=5 gives peak_valid=0.
- Edges with macro: peak at bin 1023 (mag 900, mem[1022]=40) gives nb_left=40, nb_right=0. Peak at bin 1 (mag 900) gives nb_left=0.
- Handshake: start pulsed again at cycles 10 and 1025 is ignored, leaving exactly one done. A start at cycle 1026 launches a second scan whose done arrives 1025 cycles later.
- Reset mid-scan: rst at cycle 400 gives all outputs 0 with no done. A new start then completes normally with correct results.

Source files
------------

// File: rtl/fft_peak_finder.sv
// ---------------------------------------------------------------------------
// fft_peak_finder
//
// Scans the magnitude bins of the FFT sample memory through its read port
// and reports the strongest component (bin index and magnitude). Started by
// a single-cycle start pulse; busy covers the whole scan and done pulses for
// one cycle when the result registers are updated.
//
// Scan timeline, with the accepted start in cycle 0:
//   cycles 1 .. N_BINS-MIN_BIN   SCAN   (rd_en=1, addr = MIN_BIN .. N_BINS-1)
//   cycle  N_BINS-MIN_BIN+1      DRAIN  (last read sample is compared)
//   cycle  N_BINS-MIN_BIN+2      DONE   (done=1, results visible)
//
// Optional feature (compile-time macro):
//   PEAK_NEIGHBORS_EN  adds nb_left / nb_right, the magnitudes of the bins
//                      either side of the reported peak.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       single-cycle scan request (honoured only in IDLE)
//   thresh      minimum magnitude for a valid peak, sampled on start
//   rd_en       memory read enable, high while addresses are issued
//   addr        memory read address
//   data_in     memory read data, valid one cycle after addr/rd_en
//   busy        high from the cycle after start until done inclusive
//   done        one-cycle pulse when results are updated
//   peak_bin    index of the strongest bin (lowest index wins ties)
//   peak_mag    magnitude at peak_bin
//   peak_valid  peak_mag >= thresh latched at start
//   nb_left     magnitude of bin peak_bin-1 (0 if peak is MIN_BIN)
//   nb_right    magnitude of bin peak_bin+1 (0 if peak is N_BINS-1)
// ---------------------------------------------------------------------------
module fft_peak_finder #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 10,
  parameter int N_BINS  = 1024,
  parameter int MIN_BIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] thresh,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic              peak_valid
`ifdef PEAK_NEIGHBORS_EN
  ,
  output logic [DATA_W-1:0] nb_left,
  output logic [DATA_W-1:0] nb_right
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(MIN_BIN);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(N_BINS - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] thresh_q;

  // Tag travelling alongside the read data: which address the current
  // data_in belongs to, and whether it is a real sample at all.
  logic              rd_en_d;
  logic [ADDR_W-1:0] addr_d;

  // Running maximum for the scan in progress.
  logic [DATA_W-1:0] max_mag;
  logic [ADDR_W-1:0] max_bin;
  logic [DATA_W-1:0] max_mag_nxt;
  logic [ADDR_W-1:0] max_bin_nxt;
  logic              upd;

  wire start_ok = (state == S_IDLE) && start;

  assign rd_en = (state == S_SCAN);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  // -------------------------------------------------------------------------
  // Sequencer: address generation and state
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of the
  // order of statements or blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      thresh_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SCAN;
            addr     <= FIRST_BIN;
            thresh_q <= thresh;
          end
        end
        S_SCAN: begin
          // Stop on the last bin and hold it; the address never wraps.
          if (addr == LAST_BIN) begin
            state <= S_DRAIN;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read-data tag pipeline (matches the one-cycle memory latency)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_d <= 1'b0;
      addr_d  <= '0;
    end else begin
      rd_en_d <= rd_en;
      addr_d  <= addr;
    end
  end

  // -------------------------------------------------------------------------
  // Compare stage. Strict greater-than so that ties keep the lowest bin.
  // The next-value terms are also what the result registers load in DRAIN,
  // so the final sample is included without an extra cycle.
  // -------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    upd         = 1'b0;
    max_mag_nxt = max_mag;
    max_bin_nxt = max_bin;
    if (rd_en_d && (data_in > max_mag)) begin
      upd         = 1'b1;
      max_mag_nxt = data_in;
      max_bin_nxt = addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_mag <= '0;
      max_bin <= '0;
    end else if (start_ok) begin
      max_mag <= '0;
      max_bin <= FIRST_BIN;
    end else begin
      max_mag <= max_mag_nxt;
      max_bin <= max_bin_nxt;
    end
  end

`ifdef PEAK_NEIGHBORS_EN
  // -------------------------------------------------------------------------
  // Neighbour capture. prev_mag is the sample one bin below the one being
  // compared. A new max takes prev_mag as its left neighbour and arms a
  // capture of the next sample as its right neighbour; a new max on that
  // very next sample re-arms for its own right neighbour instead.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] prev_mag;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic              right_arm;
  logic [DATA_W-1:0] left_nxt;
  logic [DATA_W-1:0] right_nxt;
  logic              right_arm_nxt;

  always_comb begin
    left_nxt      = left_q;
    right_nxt     = right_q;
    right_arm_nxt = right_arm;
    if (upd) begin
      left_nxt      = (addr_d == FIRST_BIN) ? '0 : prev_mag;
      right_nxt     = '0;
      // The last bin has no right neighbour, so nothing to wait for.
      right_arm_nxt = (addr_d != LAST_BIN);
    end else if (rd_en_d && right_arm) begin
      right_nxt     = data_in;
      right_arm_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_mag  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      right_arm <= 1'b0;
    end else if (start_ok) begin
      prev_mag  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      right_arm <= 1'b0;
    end else begin
      if (rd_en_d) begin
        prev_mag <= data_in;
      end
      left_q    <= left_nxt;
      right_q   <= right_nxt;
      right_arm <= right_arm_nxt;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Result registers: loaded on the DRAIN -> DONE edge so they are valid in
  // the done cycle, and held untouched through any following scan.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
`ifdef PEAK_NEIGHBORS_EN
      nb_left    <= '0;
      nb_right   <= '0;
`endif
    end else if (state == S_DRAIN) begin
      peak_bin   <= max_bin_nxt;
      peak_mag   <= max_mag_nxt;
      peak_valid <= (max_mag_nxt >= thresh_q);
`ifdef PEAK_NEIGHBORS_EN
      nb_left    <= left_nxt;
      nb_right   <= right_nxt;
`endif
    end
  end

endmodule
